// File: rtl/add3_seq.sv
// Digit-serial adder: one 3-bit ripple slice reused over DIGITS cycles, LSB digit first.
// Optional subtract mode is enabled by defining ADD3_SEQ_SUB_EN.

module add3 (
    input  logic [2:0] i_a,
    input  logic [2:0] i_b,
    input  logic       i_ci,
    output logic [2:0] o_s,
    output logic       o_co
);

    // Three chained full adders.
    always_comb begin : ripple
        logic c;
        o_s  = '0;
        c    = i_ci;
        for (int i = 0; i < 3; i++) begin
            o_s[i] = i_a[i] ^ i_b[i] ^ c;
            c      = (i_a[i] & i_b[i]) | (c & (i_a[i] ^ i_b[i]));
        end
        o_co = c;
    end

endmodule

module add3_seq #(
    parameter int unsigned DIGITS = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [3*DIGITS-1:0]   i_a,
    input  logic [3*DIGITS-1:0]   i_b,
    input  logic                  i_c_in,
`ifdef ADD3_SEQ_SUB_EN
    input  logic                  i_sub,
`endif
    output logic                  o_busy,
    output logic                  o_done,
    output logic [3*DIGITS-1:0]   o_sum,
    output logic                  o_c_out
);

    localparam int unsigned W  = 3 * DIGITS;
    localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic                     w_accept;
    logic                     w_last;
    logic                     w_done_nxt;

    logic [CW-1:0]            r_cnt;
    logic [DIGITS-1:0][2:0]   r_ra;
    logic [DIGITS-1:0][2:0]   r_rb;
    logic [DIGITS-1:0][2:0]   r_sum;
    logic                     r_cy;
    logic                     r_c_out;
    logic                     r_busy;
    logic                     r_done;

    logic [2:0]               w_dig_a;
    logic [2:0]               w_dig_b;
    logic [2:0]               w_dig_s;
    logic                     w_dig_co;

    logic [W-1:0]             w_b_load;
    logic                     w_cy_load;

    // Operand B / carry-in as they are latched; subtract uses ~b + 1.
`ifdef ADD3_SEQ_SUB_EN
    assign w_b_load  = i_sub ? ~i_b : i_b;
    assign w_cy_load = i_sub ? 1'b1 : i_c_in;
`else
    assign w_b_load  = i_b;
    assign w_cy_load = i_c_in;
`endif

    assign w_dig_a = r_ra[r_cnt];
    assign w_dig_b = r_rb[r_cnt];

    add3 u_slice (
        .i_a  (w_dig_a),
        .i_b  (w_dig_b),
        .i_ci (r_cy),
        .o_s  (w_dig_s),
        .o_co (w_dig_co)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (r_cnt == LAST) begin
                    w_last      = 1'b1;
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand latch on accept, one digit written per RUN cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt   <= '0;
            r_ra    <= '0;
            r_rb    <= '0;
            r_sum   <= '0;
            r_cy    <= 1'b0;
            r_c_out <= 1'b0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_ra    <= i_a;
            r_rb    <= w_b_load;
            r_cy    <= w_cy_load;
            r_sum   <= '0;
            r_c_out <= 1'b0;
        end else if (r_state == RUN) begin
            r_sum[r_cnt] <= w_dig_s;
            r_cy         <= w_dig_co;
            if (w_last) begin
                r_c_out <= w_dig_co;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == RUN);
            r_done <= w_done_nxt;
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_sum   = r_sum;
    assign o_c_out = r_c_out;

endmodule

// File: tb/tb_add3_seq.sv
// Scoreboard bench for add3_seq at DIGITS=4; subtract cases run when ADD3_SEQ_SUB_EN is defined.

module tb_add3_seq;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned W      = 3 * DIGITS;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic          c_in;
    logic          sub;
    logic          busy;
    logic          done;
    logic [W-1:0]  sum;
    logic          c_out;

    int n_tests;
    int n_fail;
    int n_done;
    logic [W:0] exp_q[$];

    add3_seq #(.DIGITS(DIGITS)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .i_c_in  (c_in),
`ifdef ADD3_SEQ_SUB_EN
        .i_sub   (sub),
`endif
        .o_busy  (busy),
        .o_done  (done),
        .o_sum   (sum),
        .o_c_out (c_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pops the expected result on every done pulse.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            if (exp_q.size() == 0) begin
                check("spurious_done", 32'(done), 32'd0);
            end else begin
                check("result", 32'({c_out, sum}), 32'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
        logic [W:0] r;
        if (s) begin
            r[W-1:0] = W'(x - y);
            r[W]     = (x >= y);
        end else begin
            r = (W+1)'(x) + (W+1)'(y) + (W+1)'(ci);
        end
        return r;
    endfunction

    // Drives start for one cycle (edge E0); returns #1 after E0.
    task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic ci, input logic s, input bit push);
        a = x; b = y; c_in = ci; sub = s; start = 1'b1;
        if (push) exp_q.push_back(model(x, y, ci, s));
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Waits for done with a cycle budget; returns #1 after the edge that raised it.
    task automatic wait_done();
        bit seen = 0;
        for (int k = 0; k < 3 * DIGITS; k++) begin
            if (done) begin seen = 1; break; end
            @(posedge clk); #1;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input logic s);
        start_op(x, y, ci, s, 1);
        wait_done();
        @(posedge clk); #1;
    endtask

    initial begin
        int d0;
        n_tests = 0; n_fail = 0; n_done = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_sum",   32'(sum),   32'd0);
        check("rst_c_out", 32'(c_out), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Basic add with cycle-exact busy/done timing.
        start_op(12'd1234, 12'd2000, 1'b0, 1'b0, 1);
        for (int k = 0; k < 3; k++) begin
            check("busy_run", 32'(busy), 32'd1);
            check("done_early", 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        check("busy_last", 32'(busy), 32'd1);
        @(posedge clk); #1;
        check("done_at_4", 32'(done), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        @(posedge clk); #1;
        check("done_pulse", 32'(done), 32'd0);
        check("sum_hold", 32'(sum), 32'd3234);

        // Full carry ripple.
        run_op(12'd4095, 12'd1, 1'b0, 1'b0);
        run_op(12'd4095, 12'd0, 1'b1, 1'b0);

        // Start while busy is ignored.
        d0 = n_done;
        start_op(12'd7, 12'd8, 1'b0, 1'b0, 1);
        @(posedge clk); #1;
        a = 12'd100; b = 12'd100; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("busy_start_dones", 32'(n_done - d0), 32'd1);
        check("busy_start_q", 32'(exp_q.size()), 32'd0);

        // Back-to-back: start in the done cycle.
        start_op(12'd5, 12'd6, 1'b0, 1'b0, 1);
        wait_done();
        a = 12'd10; b = 12'd20; c_in = 1'b0; start = 1'b1;
        exp_q.push_back(model(12'd10, 12'd20, 1'b0, 1'b0));
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", 32'(busy), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("b2b_not_yet", 32'(done), 32'd0);
        @(posedge clk); #1;
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_sum", 32'(sum), 32'd30);
        @(posedge clk); #1;

        // Reset mid-operation aborts with no done.
        d0 = n_done;
        start_op(12'd1234, 12'd2000, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_sum",   32'(sum),   32'd0);
        check("abort_c_out", 32'(c_out), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort_no_done", 32'(n_done - d0), 32'd0);
        run_op(12'd1234, 12'd2000, 1'b0, 1'b0);

        // Random adds.
        for (int i = 0; i < 6; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
        end

`ifdef ADD3_SEQ_SUB_EN
        run_op(12'd100, 12'd30, 1'b0, 1'b1);
        run_op(12'd30, 12'd100, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end
`endif

        repeat (2) @(posedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
